// File: rtl/counter_xn.sv
// counter_xn: bank of CH independent prescaled down-counters with one-shot,
// auto-reload and square-wave modes, a shared register write port, per-channel
// sticky status flags and a combined interrupt.
module counter_xn #(
  parameter int CH    = 4,
  parameter int W     = 32,
  parameter int PRE_W = 16,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic           counter_we,
  input  logic [CHW-1:0] counter_ch,
  input  logic [1:0]     counter_reg,
  input  logic [W-1:0]   counter_val,
  output logic [W-1:0]   counter_out,
  output logic [CH-1:0]  counter_OUT,
  output logic [CH-1:0]  status,
  output logic           irq
);

  localparam logic [1:0]     REG_RELOAD = 2'b00;
  localparam logic [1:0]     REG_CTRL   = 2'b01;
  localparam logic [1:0]     REG_DIV    = 2'b10;
  localparam logic [1:0]     REG_CLR    = 2'b11;
  localparam logic [1:0]     MODE_AUTO  = 2'b01;
  localparam logic [1:0]     MODE_SQR   = 2'b10;
  localparam logic [W-1:0]   ONE        = W'(1);
  localparam logic [CHW:0]   CH_N       = (CHW+1)'(CH);

  logic [W-1:0]  cnt_all [CH];
  logic [CH-1:0] ie_vec;
  logic          ch_ok;

  // Channel selects beyond the implemented range neither write nor read.
  assign ch_ok = ({1'b0, counter_ch} < CH_N);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0]     cnt_q, rld_q, cnt_nxt;
    logic [PRE_W-1:0] pre_q, div_q;
    logic [3:0]       ctl_q;
    logic             out_q, out_nxt, sts_q;
    logic             en, tick, evt, sel, clr;
    logic [1:0]       mode;

    assign en   = ctl_q[0];
    assign mode = ctl_q[2:1];
    assign tick = en && (pre_q == div_q);
    assign evt  = tick && (cnt_q == ONE);
    assign sel  = counter_we && ch_ok && (counter_ch == CHW'(i));
    // Status clear addresses channels by bit position, not by counter_ch.
    assign clr  = counter_we && (counter_reg == REG_CLR) && counter_val[i];

    // Count and waveform next-state for a running channel (mode 11 acts as one-shot).
    always_comb begin
      cnt_nxt = cnt_q;
      out_nxt = out_q;
      if (en && (mode == MODE_AUTO)) out_nxt = 1'b0;
      if (tick) begin
        if (cnt_q > ONE) begin
          cnt_nxt = cnt_q - ONE;
        end else if (cnt_q == ONE) begin
          case (mode)
            MODE_AUTO: begin cnt_nxt = rld_q; out_nxt = 1'b1;   end
            MODE_SQR:  begin cnt_nxt = rld_q; out_nxt = ~out_q; end
            default:   begin cnt_nxt = '0;    out_nxt = 1'b1;   end
          endcase
        end else if ((mode == MODE_AUTO) || (mode == MODE_SQR)) begin
          cnt_nxt = rld_q;
        end
      end
    end

    // Channel state: counting first, then register writes override it.
    always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
        cnt_q <= '0;
        rld_q <= '0;
        pre_q <= '0;
        div_q <= '0;
        ctl_q <= '0;
        out_q <= 1'b0;
        sts_q <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        out_q <= out_nxt;
        if (en) pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        // A terminal event beats a simultaneous clear.
        sts_q <= evt | (sts_q & ~clr);
        if (sel) begin
          case (counter_reg)
            REG_RELOAD: begin
              rld_q <= counter_val;
              cnt_q <= counter_val;
              pre_q <= '0;
              out_q <= 1'b0;
            end
            REG_CTRL: ctl_q <= counter_val[3:0];
            REG_DIV: begin
              div_q <= counter_val[PRE_W-1:0];
              pre_q <= '0;
            end
            default: ;
          endcase
        end
      end
    end

    assign cnt_all[i]     = cnt_q;
    assign counter_OUT[i] = out_q;
    assign status[i]      = sts_q;
    assign ie_vec[i]      = ctl_q[3];
  end

  // Readback mux of the selected channel's count.
  always_comb begin
    counter_out = '0;
    if (ch_ok) counter_out = cnt_all[counter_ch];
  end

  assign irq = |(status & ie_vec);

endmodule

// File: tb/tb_counter_xn.sv
// Testbench for counter_xn: directed scenarios plus randomized register traffic,
// all checked against a cycle-level behavioural model of the timer bank.
module tb_counter_xn;
  localparam int CH = 4, W = 16, PRE_W = 8;

  logic          clk = 1'b0, RSTN = 1'b0, counter_we = 1'b0;
  logic [1:0]    counter_ch = 2'd0, counter_reg = 2'd0;
  logic [W-1:0]  counter_val = '0;
  logic [W-1:0]  counter_out;
  logic [CH-1:0] counter_OUT, status;
  logic          irq;

  int n_chk = 0, n_fail = 0;

  // Behavioural model state
  logic [15:0] m_cnt [4], m_rld [4];
  logic [7:0]  m_pre [4], m_div [4];
  logic [1:0]  m_mode [4];
  bit          m_en [4], m_ie [4], m_o [4], m_st [4];

  always #5 clk = ~clk;

  counter_xn #(.CH(CH), .W(W), .PRE_W(PRE_W)) dut (
    .clk(clk), .RSTN(RSTN), .counter_we(counter_we), .counter_ch(counter_ch),
    .counter_reg(counter_reg), .counter_val(counter_val), .counter_out(counter_out),
    .counter_OUT(counter_OUT), .status(status), .irq(irq)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_pre[i] = 0; m_div[i] = 0; m_mode[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_o[i] = 0; m_st[i] = 0;
    end
  endtask

  // One rising edge of the model, given the write-port inputs of that cycle.
  task automatic model_step(input bit we, input int ch, input bit [1:0] rg, input logic [15:0] val);
    for (int i = 0; i < 4; i++) begin
      bit fire, at_div;
      fire = 0;
      if (m_en[i]) begin
        at_div = (m_pre[i] == m_div[i]);
        if (m_mode[i] == 2'd1) m_o[i] = 0;
        if (!at_div) m_pre[i] = m_pre[i] + 1;
        else begin
          m_pre[i] = 0;
          if (m_cnt[i] == 1) begin
            fire = 1;
            if (m_mode[i] == 2'd1) begin m_cnt[i] = m_rld[i]; m_o[i] = 1; end
            else if (m_mode[i] == 2'd2) begin m_cnt[i] = m_rld[i]; m_o[i] = !m_o[i]; end
            else begin m_cnt[i] = 0; m_o[i] = 1; end
          end else if (m_cnt[i] == 0) begin
            if (m_mode[i] == 2'd1 || m_mode[i] == 2'd2) m_cnt[i] = m_rld[i];
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
      if (we && rg == 2'd3 && val[i]) m_st[i] = 0;
      if (fire) m_st[i] = 1;
      if (we && ch == i) begin
        case (rg)
          2'd0: begin m_rld[i] = val; m_cnt[i] = val; m_pre[i] = 0; m_o[i] = 0; end
          2'd1: begin m_en[i] = val[0]; m_mode[i] = val[2:1]; m_ie[i] = val[3]; end
          2'd2: begin m_div[i] = val[7:0]; m_pre[i] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  function automatic bit term_next(input int i);
    return m_en[i] && (m_pre[i] == m_div[i]) && (m_cnt[i] == 1);
  endfunction

  function automatic logic [24:0] dut_obs();
    return {counter_out, counter_OUT, status, irq};
  endfunction

  function automatic logic [24:0] m_obs();
    logic [3:0] ov, sv;
    logic iq;
    iq = 0;
    for (int i = 0; i < 4; i++) begin
      ov[i] = m_o[i];
      sv[i] = m_st[i];
      iq = iq | (m_st[i] & m_ie[i]);
    end
    return {m_cnt[counter_ch], ov, sv, iq};
  endfunction

  // Drive one cycle starting at a falling edge; ends at the next falling edge.
  task automatic step(input bit we, input int ch, input bit [1:0] rg, input logic [15:0] val);
    counter_we = we; counter_ch = ch[1:0]; counter_reg = rg; counter_val = val;
    @(posedge clk);
    model_step(we, ch, rg, val);
    @(negedge clk);
    counter_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, int'(counter_ch), 2'd0, 16'd0);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_chk++; if (counter_out !== '0) begin n_fail++; $display("FAIL reset counter_out got %h want 0", counter_out); end
    n_chk++; if (counter_OUT !== '0) begin n_fail++; $display("FAIL reset counter_OUT got %b want 0", counter_OUT); end
    n_chk++; if (status !== '0) begin n_fail++; $display("FAIL reset status got %b want 0", status); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset irq got %b want 0", irq); end
    @(negedge clk);
    RSTN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL reset_idle got %h want %h", dut_obs(), m_obs()); end
    end
  endtask

  task automatic test_auto_reload();
    int seq [3] = '{3, 2, 1};
    step(1, 0, 2'd0, 16'd3);
    step(1, 0, 2'd1, 16'h3);
    for (int k = 0; k < 9; k++) begin
      n_chk++; if (counter_out !== W'(seq[k % 3])) begin n_fail++; $display("FAIL auto_count k%0d got %0d want %0d", k, counter_out, seq[k % 3]); end
      n_chk++; if (counter_OUT[0] !== (k > 0 && k % 3 == 0)) begin n_fail++; $display("FAIL auto_pulse k%0d got %b want %b", k, counter_OUT[0], (k > 0 && k % 3 == 0)); end
      n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL auto_model k%0d got %h want %h", k, dut_obs(), m_obs()); end
      idle(1);
    end
    n_chk++; if (status[0] !== 1'b1) begin n_fail++; $display("FAIL auto_status got %b want 1", status[0]); end
  endtask

  task automatic test_square();
    int last, toggles;
    logic prev;
    step(1, 1, 2'd2, 16'd4);
    step(1, 1, 2'd0, 16'd2);
    step(1, 1, 2'd1, 16'h5);
    last = 0; toggles = 0; prev = counter_OUT[1];
    for (int k = 0; k <= 64; k++) begin
      n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL square_model k%0d got %h want %h", k, dut_obs(), m_obs()); end
      if (counter_OUT[1] !== prev) begin
        n_chk++; if (k - last != 10) begin n_fail++; $display("FAIL square_period got %0d want 10", k - last); end
        last = k; toggles++; prev = counter_OUT[1];
      end
      idle(1);
    end
    n_chk++; if (toggles != 6) begin n_fail++; $display("FAIL square_toggles got %0d want 6", toggles); end
  endtask

  task automatic test_oneshot_irq();
    step(1, 2, 2'd0, 16'd5);
    step(1, 2, 2'd1, 16'h9);
    idle(4);
    n_chk++; if (counter_out !== W'(1) || irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_pre got cnt %0d irq %b want 1 0", counter_out, irq); end
    idle(1);
    n_chk++; if (counter_out !== '0 || counter_OUT[2] !== 1'b1 || irq !== 1'b1 || status[2] !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_done got cnt %0d out %b st %b irq %b want 0 1 1 1", counter_out, counter_OUT[2], status[2], irq); end
    idle(3);
    n_chk++; if (counter_out !== '0 || counter_OUT[2] !== 1'b1) begin n_fail++; $display("FAIL oneshot_hold got cnt %0d out %b want 0 1", counter_out, counter_OUT[2]); end
    step(1, 1, 2'd3, 16'h4);
    n_chk++; if (status[2] !== 1'b0 || irq !== 1'b0 || counter_OUT[2] !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_clear got st %b irq %b out %b want 0 0 1", status[2], irq, counter_OUT[2]); end
    n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL oneshot_model got %h want %h", dut_obs(), m_obs()); end
  endtask

  task automatic test_collisions();
    int guard;
    guard = 0;
    while (!term_next(0) && guard < 40) begin idle(1); guard++; end
    n_chk++; if (guard >= 40) begin n_fail++; $display("FAIL coll_wait1 got timeout want terminal cycle"); end
    step(1, 0, 2'd3, 16'h1);
    n_chk++; if (status[0] !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got %b want 1", status[0]); end
    step(1, 0, 2'd3, 16'h1);
    n_chk++; if (status[0] !== 1'b0) begin n_fail++; $display("FAIL coll_clear got %b want 0", status[0]); end
    guard = 0;
    while (!term_next(0) && guard < 40) begin idle(1); guard++; end
    n_chk++; if (guard >= 40) begin n_fail++; $display("FAIL coll_wait2 got timeout want terminal cycle"); end
    step(1, 0, 2'd0, 16'd7);
    n_chk++; if (counter_out !== W'(7) || counter_OUT[0] !== 1'b0 || status[0] !== 1'b1) begin
      n_fail++; $display("FAIL coll_reload got cnt %0d out %b st %b want 7 0 1", counter_out, counter_OUT[0], status[0]); end
    n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL coll_model got %h want %h", dut_obs(), m_obs()); end
  endtask

  task automatic test_freeze_and_reset();
    logic [W-1:0] v;
    logic o;
    step(1, 1, 2'd1, 16'h4);
    v = counter_out; o = counter_OUT[1];
    for (int k = 0; k < 7; k++) begin
      idle(1);
      n_chk++; if (counter_out !== v || counter_OUT[1] !== o) begin
        n_fail++; $display("FAIL freeze k%0d got cnt %0d out %b want %0d %b", k, counter_out, counter_OUT[1], v, o); end
    end
    step(1, 1, 2'd1, 16'h5);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL resume k%0d got %h want %h", k, dut_obs(), m_obs()); end
    end
    RSTN = 1'b0;
    #1;
    n_chk++; if (counter_out !== '0 || counter_OUT !== '0 || status !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", dut_obs()); end
    model_reset();
    #2 RSTN = 1'b1;
    @(posedge clk);
    model_step(0, 0, 2'd0, 16'd0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      step(0, k % 4, 2'd0, 16'd0);
      n_chk++; if (dut_obs() !== '0) begin n_fail++; $display("FAIL post_reset k%0d got %h want 0", k, dut_obs()); end
    end
  endtask

  task automatic test_random();
    bit we;
    int ch;
    bit [1:0] rg;
    logic [15:0] val;
    for (int k = 0; k < 400; k++) begin
      we = ($urandom_range(0, 3) == 0);
      ch = $urandom_range(0, 3);
      rg = 2'($urandom_range(0, 3));
      case (rg)
        2'd0: val = 16'($urandom_range(0, 6));
        2'd2: val = 16'($urandom_range(0, 3));
        default: val = 16'($urandom_range(0, 15));
      endcase
      step(we, ch, rg, val);
      n_chk++; if (dut_obs() !== m_obs()) begin n_fail++; $display("FAIL random k%0d got %h want %h", k, dut_obs(), m_obs()); end
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_square();
    test_oneshot_irq();
    test_collisions();
    test_freeze_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_xn.md
COUNTER_XN -- requirements
Module: counter_xn

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter W, default 32, count/reload width in bits.
REQ-003 SHALL have parameter PRE_W, default 16, prescaler width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port counter_we  input  1  register write strobe, one write per asserted cycle.
REQ-007 SHALL have port counter_ch  input  clog2(CH) (min 1)  channel select for writes and readback.
REQ-008 SHALL have port counter_reg  input  2  register select: 00 reload, 01 control, 10 prescale divisor, 11 status clear.
REQ-009 SHALL have port counter_val  input  W  write data.
REQ-010 SHALL have port counter_out  output  W  current count of channel counter_ch (combinational mux of registers).
REQ-011 SHALL have port counter_OUT  output  CH  per-channel waveform output bit.
REQ-012 SHALL have port status  output  CH  per-channel sticky terminal-event flag.
REQ-013 SHALL have port irq  output  1  OR over channels of (status & ie).

Function
REQ-014 Control register SHALL be: bit0 en, bits2:1 mode (00 one-shot, 01 auto-reload, 10 square wave, 11 treated as one-shot), bit3 ie; other bits ignored.
REQ-015 Per channel, when en=1 the prescaler SHALL increment each cycle; when it equals the divisor it SHALL reset to 0 and produce a one-cycle tick; divisor 0 SHALL tick every cycle.
REQ-016 en=0 SHALL freeze prescaler, count and counter_OUT; count and prescaler resume from frozen values when en returns to 1.
REQ-017 On tick with count>1, count SHALL decrement by 1.
REQ-018 On tick with count==1 (terminal event): status bit SHALL set; one-shot: count->0, counter_OUT->1 and held; auto-reload: count->reload, counter_OUT high for exactly one cycle; square: count->reload, counter_OUT toggles.
REQ-019 On tick with count==0: one-shot holds 0 with no event; auto/square load reload with no event; reload 0 SHALL therefore never generate events.
REQ-020 Write reg 00 SHALL set reload and count to counter_val, clear that channel's prescaler and counter_OUT, next cycle.
REQ-021 Write reg 01 SHALL update control next cycle without altering count, prescaler or counter_OUT.
REQ-022 Write reg 10 SHALL set divisor to counter_val[PRE_W-1:0] and clear the prescaler.
REQ-023 Write reg 11 SHALL clear status[i] for each set counter_val[i] (i<CH), independent of counter_ch.
REQ-024 Same-cycle terminal event and status-clear on one channel: set SHALL win.
REQ-025 Same-cycle terminal event and reload write on one channel: the write SHALL win (count=counter_val, counter_OUT=0), status still set.
REQ-026 counter_ch >= CH SHALL make writes no-ops and counter_out read 0.
REQ-027 All arithmetic SHALL be unsigned modulo field width; no channel affects another.

Reset
REQ-028 RSTN low SHALL immediately clear, for every channel, count, reload, prescaler, divisor, control, counter_OUT and status; counter_out, counter_OUT, status, irq read 0.
REQ-029 Reset asserted mid-count SHALL abort counting; after release no tick occurs until en is written 1.

Verification
REQ-030 CH=4: ch0 divisor 0, reload 3, control 0x3 (en, auto) -> status[0] and a 1-cycle counter_OUT[0] pulse every 3 cycles; counter_out sequence 3,2,1,3,...
REQ-031 ch1 divisor 4, reload 2, control 0x5 (en, square) -> counter_OUT[1] toggles every 10 cycles (period 20).
REQ-032 ch2 one-shot reload 5, divisor 0, ie=1 -> after 5 cycles count=0, counter_OUT[2]=1 held, irq=1; write reg11 val 0x4 -> status[2]=0, irq=0.
REQ-033 Status-clear write in same cycle as ch0 terminal event -> status[0] remains 1; reload write in terminal cycle -> count=counter_val, counter_OUT=0.
REQ-034 Mid-count en=0 for 7 cycles -> counter_out unchanged; RSTN pulse low mid-count -> all outputs 0 asynchronously, channels idle after release.
